timer_avmm_driver: RTL

//  Avalon-MM master (initiator) that programs and services the 16-bit-register interval-timer slave.
//  A host command loads a 32-bit period, starts the timer and acknowledges every timeout IRQ.
//  It also counts ticks and reads counter snapshots on request.

---
 rtl/timer_avmm_driver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/timer_avmm_driver.sv
// Avalon-MM master that programs the 16-bit interval timer, services its timeout IRQ
// and reads counter snapshots on request.
module timer_avmm_driver #(
    parameter bit          CONTINUOUS = 1'b1,
    parameter int unsigned TICK_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_start,
    input  logic              i_cmd_stop,
    input  logic              i_cmd_snap,
    input  logic [31:0]       i_cfg_period,
    output logic              o_busy,
    output logic              o_running,
    output logic              o_tick,
    output logic [TICK_W-1:0] o_tick_count,
    output logic [31:0]       o_snap_value,
    output logic              o_snap_valid,
    output logic [2:0]        o_avm_address,
    output logic              o_avm_chipselect,
    output logic              o_avm_write_n,
    output logic [15:0]       o_avm_writedata,
    input  logic [15:0]       i_avm_readdata,
    input  logic              i_avm_irq
);

    typedef enum logic [3:0] {
        StIdle, StWrPl, StWrPh, StWrCtrl, StRun, StClrTo, StStopWr,
        StSnapWr, StSnapRdl, StSnapRdh, StSnapCap
    } state_e;

    localparam logic [15:0] CtrlStart = {12'b0, 1'b0, 1'b1, CONTINUOUS, 1'b1};
    localparam logic [15:0] CtrlStop  = 16'h0008;

    state_e            r_state;
    state_e            w_state_d;
    logic              r_ret_run;
    logic              w_ret_run_d;
    logic [31:0]       r_period;
    logic [TICK_W-1:0] r_tick_count;
    logic [15:0]       r_snap_lo;
    logic [31:0]       r_snap_value;
    logic              r_snap_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_ret_run <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_ret_run <= w_ret_run_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_ret_run_d = r_ret_run;
        unique case (r_state)
            StIdle: begin
                if (i_cmd_start) begin
                    w_state_d = StWrPl;
                end else if (i_cmd_snap) begin
                    w_state_d   = StSnapWr;
                    w_ret_run_d = 1'b0;
                end
            end
            StWrPl:   w_state_d = StWrPh;
            StWrPh:   w_state_d = StWrCtrl;
            StWrCtrl: w_state_d = StRun;
            StRun: begin
                // The IRQ is a level, so it outranks commands and is never lost.
                if (i_avm_irq) begin
                    w_state_d = StClrTo;
                end else if (i_cmd_stop) begin
                    w_state_d = StStopWr;
                end else if (i_cmd_snap) begin
                    w_state_d   = StSnapWr;
                    w_ret_run_d = 1'b1;
                end
            end
            StClrTo:   w_state_d = CONTINUOUS ? StRun : StIdle;
            StStopWr:  w_state_d = StIdle;
            StSnapWr:  w_state_d = StSnapRdl;
            StSnapRdl: w_state_d = StSnapRdh;
            StSnapRdh: w_state_d = StSnapCap;
            StSnapCap: w_state_d = r_ret_run ? StRun : StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_period     <= '0;
            r_tick_count <= '0;
            r_snap_lo    <= '0;
            r_snap_value <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= 1'b0;
            if (r_state == StIdle && i_cmd_start) begin
                r_period     <= i_cfg_period;
                r_tick_count <= '0;
            end
            // Counted on entry to CLR_TO so the count is current while tick is high.
            if (r_state == StRun && i_avm_irq) begin
                r_tick_count <= r_tick_count + TICK_W'(1);
            end
            if (r_state == StSnapRdh) begin
                r_snap_lo <= i_avm_readdata;
            end
            if (r_state == StSnapCap) begin
                r_snap_value <= {i_avm_readdata, r_snap_lo};
                r_snap_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        o_avm_chipselect = 1'b0;
        o_avm_write_n    = 1'b1;
        o_avm_address    = 3'd0;
        o_avm_writedata  = 16'h0000;
        unique case (r_state)
            StWrPl: begin
                o_avm_chipselect = 1'b1;
                o_avm_write_n    = 1'b0;
                o_avm_address    = 3'd2;
                o_avm_writedata  = r_period[15:0];
            end
            StWrPh: begin
                o_avm_chipselect = 1'b1;
                o_avm_write_n    = 1'b0;
                o_avm_address    = 3'd3;
                o_avm_writedata  = r_period[31:16];
            end
            StWrCtrl: begin
                o_avm_chipselect = 1'b1;
                o_avm_write_n    = 1'b0;
                o_avm_address    = 3'd1;
                o_avm_writedata  = CtrlStart;
            end
            StClrTo: begin
                o_avm_chipselect = 1'b1;
                o_avm_write_n    = 1'b0;
                o_avm_address    = 3'd0;
            end
            StStopWr: begin
                o_avm_chipselect = 1'b1;
                o_avm_write_n    = 1'b0;
                o_avm_address    = 3'd1;
                o_avm_writedata  = CtrlStop;
            end
            StSnapWr: begin
                o_avm_chipselect = 1'b1;
                o_avm_write_n    = 1'b0;
                o_avm_address    = 3'd4;
            end
            StSnapRdl: begin
                o_avm_chipselect = 1'b1;
                o_avm_address    = 3'd4;
            end
            StSnapRdh: begin
                o_avm_chipselect = 1'b1;
                o_avm_address    = 3'd5;
            end
            default: ;
        endcase
    end

    assign o_busy       = (r_state != StIdle) && (r_state != StRun);
    assign o_running    = (r_state == StRun);
    assign o_tick       = (r_state == StClrTo);
    assign o_tick_count = r_tick_count;
    assign o_snap_value = r_snap_value;
    assign o_snap_valid = r_snap_valid;

endmodule
